// File: rtl/operand_loader_pkg.sv
// Shared constants and FSM encoding for the operand-entry stage and the adder top.
package operand_loader_pkg;

    localparam int OPERAND_WIDTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Encoding is fixed because it is driven straight onto the LEDs; 2'b11 is unreachable.
    typedef enum logic [1:0] {
        ST_WAIT_A = 2'b00,
        ST_WAIT_B = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Operand bus from the loader to the adder: registered operands, valid flag, FSM state for the LEDs.
interface operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             valid;
    logic [1:0]       state_led;

    modport master (output A, output B, output valid, output state_led);
    modport slave  (input  A, input  B, input  valid, input  state_led);
endinterface

// File: rtl/operand_loader_key_debounce.sv
// Purpose: 2-flop sync, stability-counter debounce and press detector for one active-low key.
// Latency: press_pulse 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw falling edge.
// Backpressure: none; the one-cycle pulse is never held or retried.
module key_debounce
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic press_pulse
);

    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_key;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= 1'b1;
            sync_key    <= 1'b1;
            level       <= 1'b1;
            level_d     <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_meta   <= key_raw_n;
            sync_key    <= sync_meta;
            level_d     <= level;
            press_pulse <= level_d & ~level;
            // The counter only runs while a candidate new level is pending; any
            // return to the accepted level throws the partial count away.
            if (sync_key == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_key;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Purpose: load operands A then B from the slide switches on debounced key presses; clear key zeroes both.
// Latency: A/B/valid update one cycle after the internal press pulse; all outputs registered.
// Backpressure: none; the adder consumes the operand bus combinationally every cycle.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH           = OPERAND_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             key_load_n,
    input  logic             key_clear_n,
    operand_loader_if.master opnd
);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic             load_pulse;
    logic             clear_pulse;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_nxt;
    logic             valid_q;
    logic             valid_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .key_raw_n   (key_load_n),
        .press_pulse (load_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .key_raw_n   (key_clear_n),
        .press_pulse (clear_pulse)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '1;
            sw_sync <= '1;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        valid_nxt = valid_q;
        if (clear_pulse) begin
            state_nxt = ST_WAIT_A;
            a_nxt     = '0;
            b_nxt     = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_WAIT_A: begin
                    if (load_pulse) begin
                        a_nxt     = sw_sync;
                        state_nxt = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (load_pulse) begin
                        b_nxt     = sw_sync;
                        valid_nxt = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A load here starts a fresh sum, so B is dropped with valid.
                    if (load_pulse) begin
                        a_nxt     = sw_sync;
                        b_nxt     = '0;
                        valid_nxt = 1'b0;
                        state_nxt = ST_WAIT_B;
                    end
                end
                default: begin
                    state_nxt = ST_WAIT_A;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign opnd.A         = a_q;
    assign opnd.B         = b_q;
    assign opnd.valid     = valid_q;
    assign opnd.state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a 4-cycle debounce window.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] sw = 4'b0000;
    logic       key_load_n = 1'b1;
    logic       key_clear_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int load_pulses = 0;
    int clear_pulses = 0;

    operand_loader_if #(.WIDTH(4)) bus ();

    operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .sw_in       (sw),
        .key_load_n  (key_load_n),
        .key_clear_n (key_clear_n),
        .opnd        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_load.press_pulse === 1'b1)  load_pulses++;
        if (dut.u_clear.press_pulse === 1'b1) clear_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [3:0] val, input int hold);
        sw = val;
        tick(3);
        key_load_n = 1'b0;
        tick(hold);
        key_load_n = 1'b1;
        tick(12);
    endtask

    task automatic press_clear(input int hold);
        key_clear_n = 1'b0;
        tick(hold);
        key_clear_n = 1'b1;
        tick(12);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        tick(3);
        n_cmp++; if (bus.A !== 4'b0000) begin n_bad++; $display("FAIL reset_A: got %b want 0000", bus.A); end
        n_cmp++; if (bus.B !== 4'b0000) begin n_bad++; $display("FAIL reset_B: got %b want 0000", bus.B); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.state_led !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", bus.state_led); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic_load;
        int p0;
        p0 = load_pulses;
        press_load(4'b0101, 10);
        n_cmp++; if (bus.A !== 4'b0101) begin n_bad++; $display("FAIL basic_A: got %b want 0101", bus.A); end
        n_cmp++; if (bus.state_led !== 2'b01) begin n_bad++; $display("FAIL basic_state1: got %b want 01", bus.state_led); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid1: got %b want 0", bus.valid); end
        n_cmp++; if (load_pulses !== p0 + 1) begin n_bad++; $display("FAIL basic_pulses1: got %0d want %0d", load_pulses, p0 + 1); end
        press_load(4'b0011, 10);
        n_cmp++; if (bus.B !== 4'b0011) begin n_bad++; $display("FAIL basic_B: got %b want 0011", bus.B); end
        n_cmp++; if (bus.A !== 4'b0101) begin n_bad++; $display("FAIL basic_A_hold: got %b want 0101", bus.A); end
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid2: got %b want 1", bus.valid); end
        n_cmp++; if (bus.state_led !== 2'b10) begin n_bad++; $display("FAIL basic_state2: got %b want 10", bus.state_led); end
        n_cmp++; if (load_pulses !== p0 + 2) begin n_bad++; $display("FAIL basic_pulses2: got %0d want %0d", load_pulses, p0 + 2); end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = load_pulses;
        for (int i = 0; i < 5; i++) begin
            key_load_n = 1'b0; tick(2);
            key_load_n = 1'b1; tick(2);
        end
        tick(10);
        n_cmp++; if (load_pulses !== p0) begin n_bad++; $display("FAIL bounce_nopulse: got %0d want %0d", load_pulses, p0); end
        n_cmp++; if (bus.A !== 4'b0101 || bus.B !== 4'b0011) begin n_bad++; $display("FAIL bounce_ops: got %b/%b want 0101/0011", bus.A, bus.B); end
        n_cmp++; if (bus.state_led !== 2'b10) begin n_bad++; $display("FAIL bounce_state: got %b want 10", bus.state_led); end
        for (int i = 0; i < 5; i++) begin
            key_load_n = 1'b0; tick(2);
            key_load_n = 1'b1; tick(2);
        end
        key_load_n = 1'b0;
        tick(6);
        n_cmp++; if (dut.u_load.press_pulse !== 1'b0) begin n_bad++; $display("FAIL bounce_early: got %b want 0 at +6", dut.u_load.press_pulse); end
        tick(1);
        n_cmp++; if (dut.u_load.press_pulse !== 1'b1) begin n_bad++; $display("FAIL bounce_at7: got %b want 1 at +7", dut.u_load.press_pulse); end
        tick(1);
        n_cmp++; if (dut.u_load.press_pulse !== 1'b0) begin n_bad++; $display("FAIL bounce_width: got %b want 0 at +8", dut.u_load.press_pulse); end
        key_load_n = 1'b1;
        tick(12);
        n_cmp++; if (load_pulses !== p0 + 1) begin n_bad++; $display("FAIL bounce_onepulse: got %0d want %0d", load_pulses, p0 + 1); end
        n_cmp++; if (bus.A !== 4'b0011 || bus.B !== 4'b0000 || bus.state_led !== 2'b01) begin
            n_bad++; $display("FAIL bounce_restart: got A=%b B=%b st=%b want 0011/0000/01", bus.A, bus.B, bus.state_led);
        end
    endtask

    task automatic test_restart_done;
        press_clear(10);
        n_cmp++; if (bus.state_led !== 2'b00 || bus.A !== 4'b0000) begin n_bad++; $display("FAIL restart_clear: got st=%b A=%b want 00/0000", bus.state_led, bus.A); end
        press_load(4'b1111, 10);
        press_load(4'b0001, 10);
        n_cmp++; if (bus.A !== 4'b1111 || bus.B !== 4'b0001 || bus.valid !== 1'b1) begin
            n_bad++; $display("FAIL restart_setup: got A=%b B=%b v=%b want 1111/0001/1", bus.A, bus.B, bus.valid);
        end
        press_load(4'b1000, 10);
        n_cmp++; if (bus.A !== 4'b1000) begin n_bad++; $display("FAIL restart_A: got %b want 1000", bus.A); end
        n_cmp++; if (bus.B !== 4'b0000) begin n_bad++; $display("FAIL restart_B: got %b want 0000", bus.B); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL restart_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.state_led !== 2'b01) begin n_bad++; $display("FAIL restart_state: got %b want 01", bus.state_led); end
    endtask

    task automatic test_clear_priority;
        sw = 4'b0110;
        tick(3);
        key_load_n  = 1'b0;
        key_clear_n = 1'b0;
        tick(7);
        n_cmp++; if (dut.u_load.press_pulse !== 1'b1 || dut.u_clear.press_pulse !== 1'b1) begin
            n_bad++; $display("FAIL prio_coincide: got load=%b clear=%b want 1/1", dut.u_load.press_pulse, dut.u_clear.press_pulse);
        end
        tick(1);
        n_cmp++; if (bus.state_led !== 2'b00) begin n_bad++; $display("FAIL prio_state: got %b want 00", bus.state_led); end
        n_cmp++; if (bus.A !== 4'b0000 || bus.B !== 4'b0000 || bus.valid !== 1'b0) begin
            n_bad++; $display("FAIL prio_ops: got A=%b B=%b v=%b want 0000/0000/0", bus.A, bus.B, bus.valid);
        end
        key_load_n  = 1'b1;
        key_clear_n = 1'b1;
        tick(12);
    endtask

    task automatic test_reset_mid;
        int p0;
        press_load(4'b0110, 10);
        press_load(4'b1001, 10);
        n_cmp++; if (bus.state_led !== 2'b10 || bus.B !== 4'b1001) begin n_bad++; $display("FAIL rmid_setup: got st=%b B=%b want 10/1001", bus.state_led, bus.B); end
        key_load_n = 1'b0;
        tick(4);
        n_cmp++; if (dut.u_load.cnt !== 2'd2) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 2", dut.u_load.cnt); end
        rst_n = 1'b0;
        key_load_n = 1'b1;
        #1;
        n_cmp++; if (bus.A !== 4'b0000 || bus.B !== 4'b0000 || bus.valid !== 1'b0 || bus.state_led !== 2'b00) begin
            n_bad++; $display("FAIL rmid_async: got A=%b B=%b v=%b st=%b want all zero", bus.A, bus.B, bus.valid, bus.state_led);
        end
        tick(2);
        rst_n = 1'b1;
        p0 = load_pulses;
        tick(20);
        n_cmp++; if (load_pulses !== p0) begin n_bad++; $display("FAIL rmid_nopulse: got %0d want %0d", load_pulses, p0); end
        n_cmp++; if (bus.state_led !== 2'b00 || bus.A !== 4'b0000) begin n_bad++; $display("FAIL rmid_state: got st=%b A=%b want 00/0000", bus.state_led, bus.A); end
    endtask

    task automatic test_held_key;
        int p0;
        p0 = load_pulses;
        sw = 4'b0111;
        tick(3);
        key_load_n = 1'b0;
        tick(100);
        n_cmp++; if (load_pulses !== p0 + 1) begin n_bad++; $display("FAIL held_pulses: got %0d want %0d", load_pulses, p0 + 1); end
        n_cmp++; if (bus.state_led !== 2'b01) begin n_bad++; $display("FAIL held_state: got %b want 01", bus.state_led); end
        n_cmp++; if (bus.A !== 4'b0111) begin n_bad++; $display("FAIL held_A: got %b want 0111", bus.A); end
        key_load_n = 1'b1;
        tick(12);
        n_cmp++; if (load_pulses !== p0 + 1) begin n_bad++; $display("FAIL held_release: got %0d want %0d", load_pulses, p0 + 1); end
        n_cmp++; if (bus.state_led !== 2'b01 || bus.valid !== 1'b0) begin n_bad++; $display("FAIL held_final: got st=%b v=%b want 01/0", bus.state_led, bus.valid); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bounce();
        test_restart_done();
        test_clear_priority();
        test_reset_mid();
        test_held_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
